// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32I pipeline: result-select
// codes and load funct3 values.
package riscv_pkg;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10,
    RES_IMM  = 2'b11
  } res_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Sub-word load lane select and sign/zero extension.
// Reserved funct3 codes fall back to the full word.
module load_extend
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word_i[7:0];
    unique case (addr_lo_i)
      2'd0: byte_v = word_i[7:0];
      2'd1: byte_v = word_i[15:8];
      2'd2: byte_v = word_i[23:16];
      2'd3: byte_v = word_i[31:24];
    endcase
  end

  // Halfword lane comes from addr bit 1 only.
  assign half_v = addr_lo_i[1] ? word_i[31:16]
                               : word_i[15:0];

  always_comb begin
    data_o = word_i;
    case (funct3_i)
      F3_LB:   data_o = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_v};
      F3_LH:   data_o = {{(XLEN-16){half_v[15]}}, half_v};
      F3_LHU:  data_o = {{(XLEN-16){1'b0}}, half_v};
      F3_LW:   data_o = word_i;
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB stage register, result select and retire counter.
// Define WB_LOAD_EXT_EN for sub-word load extension.
module writeback_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             mem_valid,
  input  logic             mem_reg_write,
  input  logic [4:0]       mem_rd,
  input  logic [1:0]       mem_result_sel,
  input  logic [2:0]       mem_funct3,
  input  logic [XLEN-1:0]  mem_alu_result,
  input  logic [XLEN-1:0]  mem_load_data,
  input  logic [XLEN-1:0]  mem_pc_plus4,
  input  logic [XLEN-1:0]  mem_imm,
  output logic             RegWrite,
  output logic [4:0]       w_add,
  output logic [XLEN-1:0]  RegWriteData,
  output logic             fwd_valid,
  output logic [4:0]       fwd_rd,
  output logic [XLEN-1:0]  fwd_data,
  output logic [CNT_W-1:0] retire_count
);

  logic             wb_valid_q;
  logic             wb_reg_write_q;
  logic [4:0]       wb_rd_q;
  res_sel_e         wb_sel_q;
  logic [XLEN-1:0]  wb_alu_q;
  logic [XLEN-1:0]  wb_load_q;
  logic [XLEN-1:0]  wb_pc4_q;
  logic [XLEN-1:0]  wb_imm_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [XLEN-1:0]  ld_ext;
  logic [XLEN-1:0]  sel_data;

  assign cnt_d = wb_valid_q ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_rd_q        <= '0;
      wb_sel_q       <= RES_ALU;
      wb_alu_q       <= '0;
      wb_load_q      <= '0;
      wb_pc4_q       <= '0;
      wb_imm_q       <= '0;
      cnt_q          <= '0;
    end else begin
      wb_valid_q     <= mem_valid & ~flush;
      wb_reg_write_q <= mem_reg_write;
      wb_rd_q        <= mem_rd;
      wb_sel_q       <= res_sel_e'(mem_result_sel);
      wb_alu_q       <= mem_alu_result;
      wb_load_q      <= mem_load_data;
      wb_pc4_q       <= mem_pc_plus4;
      wb_imm_q       <= mem_imm;
      cnt_q          <= cnt_d;
    end
  end

`ifdef WB_LOAD_EXT_EN
  logic [2:0] wb_funct3_q;
  logic [1:0] wb_addr_lo_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_funct3_q  <= '0;
      wb_addr_lo_q <= '0;
    end else begin
      wb_funct3_q  <= mem_funct3;
      wb_addr_lo_q <= mem_alu_result[1:0];
    end
  end

  load_extend #(
    .XLEN(XLEN)
  ) u_load_extend (
    .word_i   (wb_load_q),
    .addr_lo_i(wb_addr_lo_q),
    .funct3_i (wb_funct3_q),
    .data_o   (ld_ext)
  );
`else
  // LW-only core: funct3 is not needed downstream.
  logic unused_funct3;
  assign unused_funct3 = ^mem_funct3;
  assign ld_ext = wb_load_q;
`endif

  always_comb begin
    sel_data = wb_alu_q;
    unique case (wb_sel_q)
      RES_ALU:  sel_data = wb_alu_q;
      RES_LOAD: sel_data = ld_ext;
      RES_PC4:  sel_data = wb_pc4_q;
      RES_IMM:  sel_data = wb_imm_q;
    endcase
  end

  assign RegWrite     = wb_valid_q & wb_reg_write_q
                      & (wb_rd_q != 5'd0);
  assign w_add        = RegWrite ? wb_rd_q : 5'd0;
  assign RegWriteData = RegWrite ? sel_data : '0;
  assign fwd_valid    = RegWrite;
  assign fwd_rd       = w_add;
  assign fwd_data     = RegWriteData;
  assign retire_count = cnt_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: directed vectors,
// expected outputs queued at issue, checked by a monitor.
module tb_writeback_stage;
  import riscv_pkg::*;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam logic [31:0] LDW = 32'h8000_FF80;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             mem_valid;
  logic             mem_reg_write;
  logic [4:0]       mem_rd;
  logic [1:0]       mem_result_sel;
  logic [2:0]       mem_funct3;
  logic [XLEN-1:0]  mem_alu_result;
  logic [XLEN-1:0]  mem_load_data;
  logic [XLEN-1:0]  mem_pc_plus4;
  logic [XLEN-1:0]  mem_imm;
  logic             RegWrite;
  logic [4:0]       w_add;
  logic [XLEN-1:0]  RegWriteData;
  logic             fwd_valid;
  logic [4:0]       fwd_rd;
  logic [XLEN-1:0]  fwd_data;
  logic [CNT_W-1:0] retire_count;

  writeback_stage #(
    .XLEN (XLEN),
    .CNT_W(CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .mem_valid     (mem_valid),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .mem_result_sel(mem_result_sel),
    .mem_funct3    (mem_funct3),
    .mem_alu_result(mem_alu_result),
    .mem_load_data (mem_load_data),
    .mem_pc_plus4  (mem_pc_plus4),
    .mem_imm       (mem_imm),
    .RegWrite      (RegWrite),
    .w_add         (w_add),
    .RegWriteData  (RegWriteData),
    .fwd_valid     (fwd_valid),
    .fwd_rd        (fwd_rd),
    .fwd_data      (fwd_data),
    .retire_count  (retire_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             rw;
    logic [4:0]       wa;
    logic [31:0]      d;
    logic [CNT_W-1:0] c;
    int               id;
  } exp_t;

  exp_t             sb[$];
  exp_t             me;
  int               checks = 0;
  int               errors = 0;
  int               nid = 0;
  logic [CNT_W-1:0] cnt_m = '0;
  logic [31:0]      rf [32];

  // Register file as seen by the rest of the core.
  always @(posedge clk)
    if (RegWrite) rf[w_add] <= RegWriteData;

  function automatic logic [31:0] ldx(input logic [31:0] ext);
`ifdef WB_LOAD_EXT_EN
    return ext;
`else
    return LDW;
`endif
  endfunction

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      me = sb.pop_front();
      checks++;
      if (RegWrite !== me.rw || w_add !== me.wa
          || RegWriteData !== me.d || retire_count !== me.c
          || fwd_valid !== me.rw || fwd_rd !== me.wa
          || fwd_data !== me.d) begin
        errors++;
        $display("FAIL wb_out#%0d: got we=%0b wa=%0d d=%h cnt=%0d fv=%0b fr=%0d fd=%h, want we=%0b wa=%0d d=%h cnt=%0d",
                 me.id, RegWrite, w_add, RegWriteData, retire_count,
                 fwd_valid, fwd_rd, fwd_data, me.rw, me.wa, me.d, me.c);
      end
    end
  end

  task automatic issue(input logic v, input logic fl,
                       input logic rw, input logic [4:0] rd,
                       input logic [1:0] sel, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] ld,
                       input logic [31:0] pc4, input logic [31:0] imm,
                       input logic [31:0] exp_d);
    exp_t e;
    @(negedge clk);
    mem_valid      = v;
    flush          = fl;
    mem_reg_write  = rw;
    mem_rd         = rd;
    mem_result_sel = sel;
    mem_funct3     = f3;
    mem_alu_result = alu;
    mem_load_data  = ld;
    mem_pc_plus4   = pc4;
    mem_imm        = imm;
    e.rw = v & ~fl & rw & (rd != 5'd0);
    e.wa = e.rw ? rd : 5'd0;
    e.d  = e.rw ? exp_d : 32'd0;
    e.c  = cnt_m;
    e.id = nid++;
    if (v & ~fl) cnt_m = cnt_m + 1'b1;
    sb.push_back(e);
  endtask

  task automatic alu_op(input logic [4:0] rd, input logic [31:0] val);
    issue(1, 0, 1, rd, RES_ALU, F3_LW, val, 32'h0, 32'h0, 32'h0, val);
  endtask

  task automatic bubble();
    issue(0, 0, 0, 5'd0, RES_ALU, F3_LW, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic load(input logic [4:0] rd, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] ext);
    issue(1, 0, 1, rd, RES_LOAD, f3, addr, LDW, 32'h0, 32'h0, ldx(ext));
  endtask

  task automatic chk_zero(input string nm);
    checks++;
    if (RegWrite !== 1'b0 || w_add !== 5'd0 || RegWriteData !== 32'd0
        || fwd_valid !== 1'b0 || fwd_rd !== 5'd0 || fwd_data !== 32'd0
        || retire_count !== '0) begin
      errors++;
      $display("FAIL %s: got we=%0b wa=%0d d=%h cnt=%0d, want all zero",
               nm, RegWrite, w_add, RegWriteData, retire_count);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    flush = 0; mem_valid = 0; mem_reg_write = 0; mem_rd = 0;
    mem_result_sel = 0; mem_funct3 = 0; mem_alu_result = 0;
    mem_load_data = 0; mem_pc_plus4 = 0; mem_imm = 0;
    #2 chk_zero("reset_hold");
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    #1 chk_zero("reset_release");

    alu_op(5'd5, 32'h7);
    bubble();
    bubble();
    @(negedge clk);
    checks++;
    if (rf[5] !== 32'h7) begin
      errors++;
      $display("FAIL rf_read5: got %h, want 00000007", rf[5]);
    end

    load(5'd6,  F3_LB,  32'h1000, 32'hFFFF_FF80);
    load(5'd7,  F3_LBU, 32'h1000, 32'h0000_0080);
    load(5'd8,  F3_LH,  32'h1002, 32'hFFFF_8000);
    load(5'd9,  F3_LHU, 32'h1002, 32'h0000_8000);
    load(5'd10, F3_LW,  32'h1000, 32'h8000_FF80);
    load(5'd11, F3_LB,  32'h1001, 32'hFFFF_FFFF);
    load(5'd12, F3_LB,  32'h1003, 32'hFFFF_FF80);
    load(5'd13, F3_LH,  32'h1003, 32'hFFFF_8000);
    load(5'd14, 3'b011, 32'h1001, 32'h8000_FF80);

    issue(1, 0, 1, 5'd0, RES_ALU, F3_LW, 32'h55, 0, 0, 0, 32'h55);
    issue(1, 0, 0, 5'd4, RES_ALU, F3_LW, 32'h66, 0, 0, 0, 32'h66);
    issue(1, 1, 1, 5'd3, RES_ALU, F3_LW, 32'h99, 0, 0, 0, 32'h99);
    alu_op(5'd3, 32'h33);
    issue(1, 0, 1, 5'd1, RES_PC4, F3_LW, 32'h1, 0, 32'h104, 0, 32'h104);
    issue(1, 0, 1, 5'd2, RES_IMM, F3_LW, 32'h1, 0, 0, 32'hABCD_E000,
          32'hABCD_E000);
    alu_op(5'd15, 32'h1);
    alu_op(5'd15, 32'h2);

    // Reset asserted between edges while a write is visible.
    alu_op(5'd16, 32'hDEAD_BEEF);
    @(posedge clk);
    #3 rst = 1'b0;
    mem_valid = 1'b0;
    #1 chk_zero("async_reset");
    cnt_m = '0;
    @(posedge clk);
    #1 chk_zero("reset_hold2");
    @(negedge clk);
    rst = 1'b1;
    #1 chk_zero("reset_release2");

    for (int i = 0; i < 17; i++) alu_op(5'd17, 32'(i));
    bubble();
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
